// File: rtl/scan_dr_bank.sv
// scan_dr_bank: NUM_CH JTAG-style data registers plus a 1-bit bypass register
// sharing one TDI/TDO path. Each channel has capture, shift and update stages;
// every update checks that exactly DR_W bits were shifted since capture.
// Optional build macro SCAN_DR_TDO_REG_EN: when defined, tdo is re-timed
// through a flop and lags the combinational value by one clock.
`timescale 1ns/1ps
module scan_dr_bank #(
    parameter int NUM_CH = 3,
    parameter int DR_W   = 8,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     tdi,
    input  logic                     capture_dr,
    input  logic                     shift_dr,
    input  logic                     update_dr,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DR_W-1:0]   capture_data,
    output logic                     tdo,
    output logic [NUM_CH*DR_W-1:0]   update_data,
    output logic [NUM_CH-1:0]        update_valid,
    output logic                     length_err,
    output logic [CNT_W-1:0]         shift_cnt
);

    // Any select value at or above NUM_CH is folded onto this single bypass code.
    localparam logic [SEL_W-1:0] BYPASS_SEL = SEL_W'(NUM_CH);
    localparam logic [CNT_W-1:0] FULL_LEN   = CNT_W'(DR_W);

    logic [NUM_CH-1:0][DR_W-1:0] sr;
    logic                        bypass_q;
    logic [SEL_W-1:0]            sel_q;
    logic [SEL_W-1:0]            sel_next;
    logic                        sel_is_byp;
    logic                        do_capture;
    logic                        do_shift;
    logic                        do_update;
    logic                        tdo_comb;

    // Saturating increment: the counter sticks at all-ones instead of wrapping,
    // so a long over-shift can never alias back to a legal DR_W count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // One operation per cycle: capture beats shift beats update.
    assign do_capture = capture_dr;
    assign do_shift   = shift_dr & ~capture_dr;
    assign do_update  = update_dr & ~capture_dr & ~shift_dr;

    assign sel_next   = (sel < BYPASS_SEL) ? sel : BYPASS_SEL;
    assign sel_is_byp = (sel_q >= BYPASS_SEL);

    // Capture/shift path: select latch, shift registers, bypass bit, counter, length flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_q      <= BYPASS_SEL;
            sr         <= '0;
            bypass_q   <= 1'b0;
            shift_cnt  <= '0;
            length_err <= 1'b0;
        end else if (do_capture) begin
            sel_q <= sel_next;
            for (int k = 0; k < NUM_CH; k++) begin
                if (sel_next == SEL_W'(k)) sr[k] <= capture_data[k*DR_W +: DR_W];
            end
            if (sel_next >= BYPASS_SEL) bypass_q <= 1'b0;
            shift_cnt  <= '0;
            length_err <= 1'b0;
        end else if (do_shift) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (sel_q == SEL_W'(k)) sr[k] <= {tdi, sr[k][DR_W-1:1]};
            end
            if (sel_is_byp) bypass_q <= tdi;
            shift_cnt <= sat_inc(shift_cnt);
        end else if (do_update && !sel_is_byp) begin
            length_err <= (shift_cnt != FULL_LEN);
        end
    end

    // Update latches and their one-cycle valid pulse, written only on a full-length scan.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            update_data  <= '0;
            update_valid <= '0;
        end else begin
            update_valid <= '0;
            if (do_update && !sel_is_byp && (shift_cnt == FULL_LEN)) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (sel_q == SEL_W'(k)) begin
                        update_data[k*DR_W +: DR_W] <= sr[k];
                        update_valid[k]             <= 1'b1;
                    end
                end
            end
        end
    end

    // Serial output mux: LSB of the selected channel, or the bypass bit.
    always_comb begin
        tdo_comb = bypass_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_q == SEL_W'(k)) tdo_comb = sr[k][0];
        end
    end

`ifdef SCAN_DR_TDO_REG_EN
    logic tdo_q;

    // Re-time tdo through a flop; it follows the mux one clock later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) tdo_q <= 1'b0;
        else          tdo_q <= tdo_comb;
    end

    assign tdo = tdo_q;
`else
    assign tdo = tdo_comb;
`endif

endmodule

// File: tb/tb_scan_dr_bank.sv
// Directed bench for scan_dr_bank (NUM_CH=3, DR_W=8, SEL_W=2, CNT_W=8).
`timescale 1ns/1ps
module tb_scan_dr_bank;
    localparam int NUM_CH = 3;
    localparam int DR_W   = 8;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   tdi;
    logic                   capture_dr;
    logic                   shift_dr;
    logic                   update_dr;
    logic [SEL_W-1:0]       sel;
    logic [NUM_CH*DR_W-1:0] capture_data;
    logic                   tdo;
    logic [NUM_CH*DR_W-1:0] update_data;
    logic [NUM_CH-1:0]      update_valid;
    logic                   length_err;
    logic [CNT_W-1:0]       shift_cnt;

    int errors = 0;
    int checks = 0;

    scan_dr_bank #(.NUM_CH(NUM_CH), .DR_W(DR_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .tdi(tdi), .capture_dr(capture_dr),
        .shift_dr(shift_dr), .update_dr(update_dr), .sel(sel),
        .capture_data(capture_data), .tdo(tdo), .update_data(update_data),
        .update_valid(update_valid), .length_err(length_err), .shift_cnt(shift_cnt)
    );

    always #5 clock = ~clock;

    // Drive one cycle of strobes, let the edge pass, then release the strobes.
    task automatic cyc(input logic c, input logic s, input logic u, input logic t);
        capture_dr = c; shift_dr = s; update_dr = u; tdi = t;
        @(posedge clock); #1;
        capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; tdi = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
        sel = '0;
        capture_data = {8'h3C, 8'hA5, 8'h5A};
        #2;
        checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo: got %0h expected 0", tdo); end
        checks++; if (update_data !== 24'h0) begin errors++; $display("FAIL reset_update_data: got %h expected 000000", update_data); end
        checks++; if (update_valid !== 3'b000) begin errors++; $display("FAIL reset_update_valid: got %b expected 000", update_valid); end
        checks++; if (length_err !== 1'b0) begin errors++; $display("FAIL reset_length_err: got %0h expected 0", length_err); end
        checks++; if (shift_cnt !== 8'd0) begin errors++; $display("FAIL reset_shift_cnt: got %0d expected 0", shift_cnt); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_ch1_scan;
        logic [7:0] v;
        logic       exp_t;
        v = 8'hA5;
        sel = 2'd1;
        for (int j = 0; j <= 8; j++) begin
            if (j == 0) cyc(1'b1, 1'b0, 1'b0, 1'b0);
            else        cyc(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SCAN_DR_TDO_REG_EN
            exp_t = (j == 0) ? 1'b0 : v[j-1];
`else
            exp_t = (j < 8) ? v[j] : 1'b0;
`endif
            checks++; if (tdo !== exp_t) begin errors++; $display("FAIL ch1_tdo[%0d]: got %0h expected %0h", j, tdo, exp_t); end
        end
        checks++; if (shift_cnt !== 8'd8) begin errors++; $display("FAIL ch1_shift_cnt: got %0d expected 8", shift_cnt); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (update_data[15:8] !== 8'h00) begin errors++; $display("FAIL ch1_update_data: got %h expected 00", update_data[15:8]); end
        checks++; if (update_valid !== 3'b010) begin errors++; $display("FAIL ch1_update_valid: got %b expected 010", update_valid); end
        checks++; if (length_err !== 1'b0) begin errors++; $display("FAIL ch1_length_err: got %0h expected 0", length_err); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (update_valid !== 3'b000) begin errors++; $display("FAIL ch1_valid_drop: got %b expected 000", update_valid); end
    endtask

    task automatic test_ch0_scan;
        logic [7:0] pat;
        pat = 8'hB3;
        sel = 2'd0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, pat[i]);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (update_data !== 24'h0000B3) begin errors++; $display("FAIL ch0_update_data: got %h expected 0000b3", update_data); end
        checks++; if (update_valid !== 3'b001) begin errors++; $display("FAIL ch0_update_valid: got %b expected 001", update_valid); end
    endtask

    task automatic test_length_check;
        sel = 2'd2;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (length_err !== 1'b1) begin errors++; $display("FAIL len_zero_err: got %0h expected 1", length_err); end
        checks++; if (update_valid !== 3'b000) begin errors++; $display("FAIL len_zero_valid: got %b expected 000", update_valid); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        checks++; if (shift_cnt !== 8'd5) begin errors++; $display("FAIL len_shift_cnt: got %0d expected 5", shift_cnt); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (update_valid !== 3'b000) begin errors++; $display("FAIL len_short_valid: got %b expected 000", update_valid); end
        checks++; if (update_data[23:16] !== 8'h00) begin errors++; $display("FAIL len_short_data: got %h expected 00", update_data[23:16]); end
        checks++; if (length_err !== 1'b1) begin errors++; $display("FAIL len_short_err: got %0h expected 1", length_err); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (length_err !== 1'b1) begin errors++; $display("FAIL len_sticky: got %0h expected 1", length_err); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (length_err !== 1'b0) begin errors++; $display("FAIL len_clear_err: got %0h expected 0", length_err); end
        checks++; if (shift_cnt !== 8'd0) begin errors++; $display("FAIL len_clear_cnt: got %0d expected 0", shift_cnt); end
`ifndef SCAN_DR_TDO_REG_EN
        checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL ch2_capture_tdo: got %0h expected 0", tdo); end
`endif
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 260; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (shift_cnt !== 8'd255) begin errors++; $display("FAIL sat_shift_cnt: got %0d expected 255", shift_cnt); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (length_err !== 1'b1) begin errors++; $display("FAIL sat_length_err: got %0h expected 1", length_err); end
        checks++; if (update_valid !== 3'b000) begin errors++; $display("FAIL sat_valid: got %b expected 000", update_valid); end
    endtask

    task automatic test_bypass;
        logic [2:0] pat;
        pat = 3'b101;
        sel = 2'd3;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
`ifndef SCAN_DR_TDO_REG_EN
        checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL byp_capture_tdo: got %0h expected 0", tdo); end
`endif
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, pat[i]);
`ifndef SCAN_DR_TDO_REG_EN
            checks++; if (tdo !== pat[i]) begin errors++; $display("FAIL byp_tdo[%0d]: got %0h expected %0h", i, tdo, pat[i]); end
`endif
        end
        checks++; if (shift_cnt !== 8'd3) begin errors++; $display("FAIL byp_shift_cnt: got %0d expected 3", shift_cnt); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (update_valid !== 3'b000) begin errors++; $display("FAIL byp_valid: got %b expected 000", update_valid); end
        checks++; if (length_err !== 1'b0) begin errors++; $display("FAIL byp_length_err: got %0h expected 0", length_err); end
        checks++; if (update_data !== 24'h0000B3) begin errors++; $display("FAIL byp_update_data: got %h expected 0000b3", update_data); end
    endtask

    task automatic test_priority;
        sel = 2'd1;
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        checks++; if (shift_cnt !== 8'd0) begin errors++; $display("FAIL prio_cap_shift_cnt: got %0d expected 0", shift_cnt); end
`ifndef SCAN_DR_TDO_REG_EN
        checks++; if (tdo !== 1'b1) begin errors++; $display("FAIL prio_cap_tdo: got %0h expected 1", tdo); end
`endif
        sel = 2'd0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
`ifndef SCAN_DR_TDO_REG_EN
        checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL sel_change_tdo: got %0h expected 0", tdo); end
`endif
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (shift_cnt !== 8'd8) begin errors++; $display("FAIL prio_shift_upd_cnt: got %0d expected 8", shift_cnt); end
        checks++; if (update_valid !== 3'b000) begin errors++; $display("FAIL prio_shift_upd_valid: got %b expected 000", update_valid); end
        checks++; if (update_data[15:8] !== 8'h00) begin errors++; $display("FAIL prio_shift_upd_data: got %h expected 00", update_data[15:8]); end
    endtask

    task automatic test_back_to_back;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (update_data[15:8] !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %h expected ff", update_data[15:8]); end
        checks++; if (update_valid !== 3'b010) begin errors++; $display("FAIL b2b_valid_1: got %b expected 010", update_valid); end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (update_valid !== 3'b010) begin errors++; $display("FAIL b2b_valid_2: got %b expected 010", update_valid); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (update_valid !== 3'b000) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 000", update_valid); end
        sel = 2'd1;
        capture_data = {8'h3C, 8'h11, 8'h5A};
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (update_valid !== 3'b000) begin errors++; $display("FAIL prio_cap_upd_valid: got %b expected 000", update_valid); end
        checks++; if (update_data[15:8] !== 8'hFF) begin errors++; $display("FAIL prio_cap_upd_data: got %h expected ff", update_data[15:8]); end
        capture_data = {8'h3C, 8'hA5, 8'h5A};
    endtask

    task automatic test_reset_mid_shift;
        sel = 2'd1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++; if (shift_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_shift_cnt: got %0d expected 0", shift_cnt); end
        checks++; if (update_data !== 24'h0) begin errors++; $display("FAIL rst_mid_update_data: got %h expected 000000", update_data); end
        checks++; if (length_err !== 1'b0) begin errors++; $display("FAIL rst_mid_length_err: got %0h expected 0", length_err); end
        checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL rst_mid_tdo: got %0h expected 0", tdo); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
`ifndef SCAN_DR_TDO_REG_EN
        checks++; if (tdo !== 1'b1) begin errors++; $display("FAIL rst_bypass_tdo: got %0h expected 1", tdo); end
`endif
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (shift_cnt !== 8'd0) begin errors++; $display("FAIL rst_recap_cnt: got %0d expected 0", shift_cnt); end
`ifndef SCAN_DR_TDO_REG_EN
        checks++; if (tdo !== 1'b1) begin errors++; $display("FAIL rst_recap_tdo: got %0h expected 1", tdo); end
`endif
    endtask

    initial begin
        test_reset();
        test_ch1_scan();
        test_ch0_scan();
        test_length_check();
        test_saturate();
        test_bypass();
        test_priority();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_dr_bank.md
Name: scan_dr_bank

Overview:
- Parametrised bank of NUM_CH JTAG-style data registers plus a 1-bit bypass register, all sharing one TDI/TDO path.
- Each channel provides capture, shift and update stages, with a shift-length check on every update.
- The TDO source is selected by the channel index latched at capture.
- Sits between the TAP controller / IR decode (which drive capture_dr, shift_dr, update_dr, sel) and the core-side registers (capture_data in, update_data out).

Parameters:
- NUM_CH, 3, number of data-register channels (1..2^SEL_W-1); index NUM_CH and above selects bypass.
- DR_W, 8, bit width of each channel's data register (>=2).
- SEL_W, 2, width of the channel-select input.
- CNT_W, 8, width of the shift counter; must satisfy 2^CNT_W-1 > DR_W.

Ports:
- clock, input, 1, single system clock; all state updates on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- tdi, input, 1, serial scan data in.
- capture_dr, input, 1, capture strobe (one cycle per Capture-DR).
- shift_dr, input, 1, shift enable (high for each Shift-DR cycle).
- update_dr, input, 1, update strobe (one cycle per Update-DR).
- sel, input, SEL_W, channel select from IR decode; sampled only on capture.
- capture_data, input, NUM_CH*DR_W, parallel capture values; channel k occupies [k*DR_W +: DR_W].
- tdo, output, 1, serial scan data out.
- update_data, output, NUM_CH*DR_W, parallel update latches per channel, same packing as capture_data.
- update_valid, output, NUM_CH, one-cycle pulse per channel when its update_data is written.
- length_err, output, 1, sticky flag: last update saw a shift count other than DR_W.
- shift_cnt, output, CNT_W, shifts since last capture, saturating.

Behaviour:

Reset (reset_n low, asynchronous):
- All shift registers, bypass bit, update_data, update_valid, length_err and shift_cnt are 0.
- sel_q = NUM_CH (bypass).
- tdo = 0.

Strobe priority:
- Only one operation is honoured per cycle, in the order capture_dr > shift_dr > update_dr.
- A lower-priority strobe asserted in the same cycle is ignored entirely, with no partial effect.

Capture:
- sel_q <= (sel < NUM_CH) ? sel : NUM_CH.
- The newly selected channel's shift register <= its capture_data slice.
- If bypass is selected, the bypass bit <= 0.
- shift_cnt <= 0; length_err <= 0.
- Unselected channel shift registers hold their contents.

Shift:
- Selected channel register <= {tdi, sr[DR_W-1:1]}, i.e. LSB out first, tdi enters the MSB.
- Bypass selected: bypass bit <= tdi.
- shift_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- Unselected registers hold.

Update, with sel_q < NUM_CH:
- shift_cnt == DR_W: update_data slice sel_q <= shift register; update_valid[sel_q] = 1 for exactly the next cycle; length_err <= 0.
- shift_cnt != DR_W (including 0 and saturated): update_data unchanged, no pulse, length_err <= 1.
- length_err remains set until the next capture or reset.

Update, with bypass selected:
- No data effect, no pulse, length_err unchanged.

TDO (combinational from state):
- tdo = sel_q < NUM_CH ? sr[sel_q][0] : bypass bit.
- After capture, tdo shows capture_data bit 0 of the selected channel with zero additional latency.

sel behaviour:
- Changes to sel between captures have no effect.

update_valid:
- Low on every cycle other than the single pulse cycle.
- Back-to-back valid updates produce one pulse per update strobe.

Reset mid-shift:
- Every register returns to its reset value immediately.
- The next operation behaves as a fresh capture.

Optional Feature:
- Macro: SCAN_DR_TDO_REG_EN.
- Defined: tdo is driven from a flop loaded every cycle with the combinational tdo value, so it lags one clock. The flop resets to 0.
- Undefined: tdo is combinational as specified above, with zero latency.
- Shift/update/length-check semantics are identical in both builds.

Test Plan:
- Reset, then sel=1, capture with channel-1 capture_data=8'hA5 -> tdo=1. Shift 8 cycles with tdi=0 -> tdo sequence 1,0,1,0,0,1,0,1. Update -> update_data ch1=8'h00, update_valid=3'b010 for one cycle, length_err=0.
- sel=0, capture; shift tdi pattern 1,1,0,0,1,1,0,1 (8 cycles); update -> ch0 update_data=8'hB3, pulse on bit 0 only; ch1/ch2 update_data unchanged.
- sel=2, capture, shift 5 cycles, update -> no pulse, ch2 update_data unchanged, length_err=1, shift_cnt=5. Next capture -> length_err=0, shift_cnt=0.
- sel=3 (bypass), capture, shift tdi 1,0,1 -> tdo 0,1,0,1 (one-cycle delay); update -> no pulse, length_err unchanged.
- capture_dr and shift_dr high together -> only capture occurs (shift_cnt=0). shift_dr and update_dr together after 7 shifts -> shift only, shift_cnt=8, no pulse. Change sel mid-shift -> tdo source unchanged.
- reset_n low during shift of ch1 -> all outputs 0 asynchronously, sel_q=bypass. With SCAN_DR_TDO_REG_EN defined, repeat the first scenario -> same sequence delayed one clock.
